// File: rtl/imem_fetch_buf.sv
// imem_fetch_buf: writable instruction memory with a 1-cycle read and 2-entry response buffer
module imem_fetch_buf #(
  parameter int N      = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [N-1:0]      ld_data,
  output logic              ld_ready,
  output logic              ld_err,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [N-1:0]      rsp_data,
  output logic              rsp_fault,
  input  logic              rsp_ready
);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;
  localparam logic [ADDR_W:0] DEP = (ADDR_W+1)'(DEPTH);
  logic [N-1:0]      mem [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              sk_valid, sk_fault;
  logic [N-1:0]      sk_data;
  logic              run, ld_acc, ld_in, acc, req_fault, adv;
  logic [N-1:0]      rd_data;
  always_comb begin
    run       = state == RUN;
    ld_ready  = run;
    req_ready = run && !(rsp_valid && sk_valid);
    ld_acc    = ld_en && run;
    ld_in     = {1'b0, ld_addr} < DEP;
    acc       = req_valid && req_ready;
    req_fault = !({1'b0, req_addr} < DEP);
    adv       = !rsp_valid || rsp_ready;
    // write-first bypass so a same-cycle load is visible to the fetch
    rd_data   = req_fault ? '0 :
                (ld_acc && ld_in && ld_addr == req_addr) ? ld_data : mem[req_addr];
  end
  always_ff @(posedge clk) begin
    if (!run) mem[clr_cnt] <= '0;
    else if (ld_acc && ld_in) mem[ld_addr] <= ld_data;
  end
  // output register is the buffer head; skid entry holds the second response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      ld_err    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_fault <= 1'b0;
      sk_valid  <= 1'b0;
      sk_data   <= '0;
      sk_fault  <= 1'b0;
    end else begin
      if (!run) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == ADDR_W'(DEPTH - 1)) state <= RUN;
      end
      ld_err <= ld_acc && !ld_in;
      if (adv) begin
        rsp_valid <= sk_valid || acc;
        if (sk_valid) begin
          rsp_data  <= sk_data;
          rsp_fault <= sk_fault;
        end else if (acc) begin
          rsp_data  <= rd_data;
          rsp_fault <= req_fault;
        end
        sk_valid <= sk_valid && acc;
        if (sk_valid && acc) begin
          sk_data  <= rd_data;
          sk_fault <= req_fault;
        end
      end else if (acc) begin
        sk_valid <= 1'b1;
        sk_data  <= rd_data;
        sk_fault <= req_fault;
      end
    end
  end
endmodule
